traffic_phase_sequencer: RTL
============================

# traffic_phase_sequencer

N-phase, demand-actuated traffic-light sequencer. Generalised successor to the fixed four-approach controller: parametrised phase count and timing, latched per-phase vehicle demand, round-robin service, minimum-green, fixed yellow, and an optional all-red clearance interval. Sits between the per-approach vehicle detectors and the lamp drivers. All lamp outputs are decoded from registered state.

## Interface
- NPHASE, 4, number of signal phases (≥2)
- WL, 4, interval counter width; GREEN_T-1, YELLOW_T-1, ALLRED_T-1 must each be < 2^WL
- GREEN_T, 8, minimum green length in cycles (≥1)
- YELLOW_T, 3, yellow length in cycles (≥1)
- ALLRED_T, 1, all-red clearance length in cycles (≥1)

- CLK  in  1  single clock; all state changes on its rising edge
- RST  in  1  synchronous, active-high reset
- Car  in  NPHASE  vehicle-present request per phase, sampled every rising edge
- Green  out  NPHASE  green lamp per phase
- Yellow  out  NPHASE  yellow lamp per phase
- Red  out  NPHASE  red lamp per phase
- Phase  out  $clog2(NPHASE)  index of the current or last-served phase

## Operation
- States: ALLRED, GREEN, YELLOW. Down-counter cnt (WL bits) loaded with T-1 on state entry; it holds at 0 when the state does not advance.
- Demand: pending[i] is set when Car[i]=1. Exception: Car[Phase] is ignored while in GREEN. pending[i] is cleared on the edge where phase i enters GREEN, and clearing wins over setting on that edge.
- Picker: the first i with pending[i]=1, searching Phase+1, Phase+2, … modulo NPHASE. Phase itself is searched last.
- ALLRED, cnt==0, pending≠0: go to GREEN with Phase=pick and cnt=GREEN_T-1. If pending==0, stay in ALLRED (rest in red).
- GREEN, cnt==0, any pending[j] with j≠Phase: go to YELLOW with cnt=YELLOW_T-1. Otherwise stay in GREEN (rest in green).
- YELLOW, cnt==0: go to ALLRED with cnt=ALLRED_T-1. See Configuration for the variant without all-red.
- Lamp decode: for every phase, exactly one of Green/Yellow/Red is 1. Phase Phase is Green in GREEN and Yellow in YELLOW. Every other phase, and every phase in ALLRED, is Red.
- Reset: state=ALLRED, cnt=ALLRED_T-1, pending=0, Phase=NPHASE-1. Outputs: Green=0, Yellow=0, Red=all ones. RST wins over Car on the same edge. Reset mid-interval aborts the interval immediately.

## Timing
- Car sampled at edge k → pending set at edge k → earliest GREEN entry at edge k+1.
- Green lasts ≥GREEN_T cycles. Yellow lasts exactly YELLOW_T cycles. All-red lasts exactly ALLRED_T cycles when a request is pending.
- Changeover from leaving GREEN to next green: YELLOW_T+ALLRED_T cycles.
- With NPHASE phases all continuously requesting: service is strictly round-robin, and no phase waits more than NPHASE-1 service slots.

## Configuration
- TLC_ALLRED_EN defined: behaviour as above.
- TLC_ALLRED_EN undefined:
  - YELLOW at cnt==0 goes directly to GREEN of pick, or to ALLRED if pending==0.
  - ALLRED is reached only from reset or idle; its entry load is 0 and ALLRED_T is unused.
  - Changeover is YELLOW_T cycles.

## Structure
- Shared package traffic_pkg holds:
  - the state enum (ALLRED, GREEN, YELLOW)
  - the default timing constants
  - the phase-index width function
- One sub-module, tlc_rr_picker: a combinational round-robin search over pending, starting after Phase. Outputs the pick index and a valid flag; parametrised on NPHASE.

## Test plan
Defaults apply and TLC_ALLRED_EN is defined unless stated.
- Reset, Car=0 for 20 cycles → Red=4'b1111, Green=0, Yellow=0, Phase=3 throughout.
- After reset, pulse Car=4'b0100 for one cycle → Green=4'b0100 and Phase=2 two edges after the pulse. Green stays on indefinitely with no further Car.
- Phase 2 green for 3 cycles, pulse Car[0] → green ends after exactly 8 cycles, then Yellow=4'b0100 for 3 cycles, then Red=4'b1111 for 1 cycle, then Green=4'b0001.
- Car=4'b1011 held from reset → served phase order 0,1,3,0,1,3. Phase 2 never green.
- RST asserted in the 2nd yellow cycle, together with Car=4'b0010 → after that edge Red=4'b1111, pending=0, Phase=3. Next green occurs only on a new request.
- TLC_ALLRED_EN undefined, phase 0 green, pulse Car[1] → after 8 green and 3 yellow cycles, Green=4'b0010 on the very next cycle, with no all-red cycle.

Source files
------------

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared state enum, default timing and phase-index width for the traffic sequencer
package traffic_pkg;

  typedef enum logic [1:0] {
    ALLRED = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2
  } tlc_state_t;

  localparam int DEF_NPHASE   = 4;
  localparam int DEF_WL       = 4;
  localparam int DEF_GREEN_T  = 8;
  localparam int DEF_YELLOW_T = 3;
  localparam int DEF_ALLRED_T = 1;

  function automatic int phase_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tlc_rr_picker.sv
// rtl/tlc_rr_picker.sv - combinational round-robin search over pending demand, starting after the current phase
module tlc_rr_picker
  import traffic_pkg::*;
#(
  parameter int NPHASE = DEF_NPHASE,
  localparam int PW = phase_w(NPHASE)
) (
  input  logic [NPHASE-1:0] pending,
  input  logic [PW-1:0]     phase,
  output logic [PW-1:0]     pick,
  output logic              valid
);

  logic [PW-1:0] idx;

  // Walk from the farthest candidate back to the nearest so the nearest hit wins;
  // the current phase itself is offset NPHASE, i.e. searched last.
  always_comb begin
    pick  = phase;
    valid = 1'b0;
    idx   = phase;
    for (int k = NPHASE; k >= 1; k--) begin
      idx = PW'((int'(phase) + k) % NPHASE);
      if (pending[idx]) begin
        pick  = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// rtl/traffic_phase_sequencer.sv - N-phase demand-actuated signal sequencer; all-red clearance enabled by TLC_ALLRED_EN
module traffic_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int NPHASE   = DEF_NPHASE,
  parameter int WL       = DEF_WL,
  parameter int GREEN_T  = DEF_GREEN_T,
  parameter int YELLOW_T = DEF_YELLOW_T,
  parameter int ALLRED_T = DEF_ALLRED_T,
  localparam int PW = phase_w(NPHASE)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NPHASE-1:0] Car,
  output logic [NPHASE-1:0] Green,
  output logic [NPHASE-1:0] Yellow,
  output logic [NPHASE-1:0] Red,
  output logic [PW-1:0]     Phase
);

`ifdef TLC_ALLRED_EN
  localparam bit AR_EN = 1'b1;
`else
  localparam bit AR_EN = 1'b0;
`endif

  localparam logic [WL-1:0] GREEN_LD  = WL'(GREEN_T - 1);
  localparam logic [WL-1:0] YELLOW_LD = WL'(YELLOW_T - 1);
  // Without clearance, all-red is only an idle/reset rest state and needs no dwell.
  localparam logic [WL-1:0] ALLRED_LD = AR_EN ? WL'(ALLRED_T - 1) : '0;
  localparam logic [PW-1:0] PHASE_RST = PW'(NPHASE - 1);
  localparam logic [NPHASE-1:0] ONE   = {{(NPHASE-1){1'b0}}, 1'b1};

  tlc_state_t        state, state_nxt;
  logic [WL-1:0]     cnt, cnt_nxt;
  logic [NPHASE-1:0] pending, pending_nxt;
  logic [PW-1:0]     phase_nxt;
  logic [PW-1:0]     pick;
  logic              pick_valid;
  logic              cnt_done;
  logic              other_pending;
  logic              enter_green;
  logic [NPHASE-1:0] phase_bit;
  logic [NPHASE-1:0] car_mask;

  tlc_rr_picker #(.NPHASE(NPHASE)) u_picker (
    .pending (pending),
    .phase   (Phase),
    .pick    (pick),
    .valid   (pick_valid)
  );

  assign cnt_done      = (cnt == '0);
  assign phase_bit     = ONE << Phase;
  assign other_pending = |(pending & ~phase_bit);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ALLRED;
      cnt     <= ALLRED_LD;
      pending <= '0;
      Phase   <= PHASE_RST;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pending <= pending_nxt;
      Phase   <= phase_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    phase_nxt   = Phase;
    cnt_nxt     = cnt_done ? cnt : cnt - WL'(1);
    enter_green = 1'b0;
    case (state)
      ALLRED: begin
        if (cnt_done && pick_valid) begin
          state_nxt   = GREEN;
          phase_nxt   = pick;
          cnt_nxt     = GREEN_LD;
          enter_green = 1'b1;
        end
      end
      GREEN: begin
        if (cnt_done && other_pending) begin
          state_nxt = YELLOW;
          cnt_nxt   = YELLOW_LD;
        end
      end
      YELLOW: begin
        if (cnt_done) begin
`ifdef TLC_ALLRED_EN
          state_nxt = ALLRED;
          cnt_nxt   = ALLRED_LD;
`else
          if (pick_valid) begin
            state_nxt   = GREEN;
            phase_nxt   = pick;
            cnt_nxt     = GREEN_LD;
            enter_green = 1'b1;
          end else begin
            state_nxt = ALLRED;
            cnt_nxt   = ALLRED_LD;
          end
`endif
        end
      end
      default: begin
        state_nxt = ALLRED;
        cnt_nxt   = ALLRED_LD;
      end
    endcase

    // The served phase cannot re-request itself while green; entry clear beats a same-edge set.
    car_mask    = (state == GREEN) ? ~phase_bit : '1;
    pending_nxt = pending | (Car & car_mask);
    if (enter_green) pending_nxt = pending_nxt & ~(ONE << phase_nxt);
  end

  always_comb begin
    Green  = '0;
    Yellow = '0;
    Red    = '1;
    if (state == GREEN) begin
      Green = phase_bit;
      Red   = ~phase_bit;
    end else if (state == YELLOW) begin
      Yellow = phase_bit;
      Red    = ~phase_bit;
    end
  end

endmodule
